// File: rtl/dsp_mac_casc_param.sv
// One cascadable DSP multiply-accumulate slice: W x W product plus optional C and a selectable
// Z source, with mode/shift/valid travelling beside their operands so each op carries its own control.
module dsp_mac_casc_param #(
    parameter int W     = 17,
    parameter int P_W   = 48,
    parameter int ABREG = 1,
    parameter int MREG  = 1,
    parameter int CREG  = 1
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             ce_i,
    input  logic             valid_i,
    input  logic [3:0]       mode_i,
    input  logic             shift_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             c_en_i,
    input  logic [2*W-1:0]   c_i,
    input  logic [P_W-1:0]   pcin_i,
    output logic [2*W-1:0]   p_o,
    output logic [P_W-1:0]   pcout_o,
    output logic             valid_o
);

    localparam int CTL_DEPTH = ABREG + MREG;

    logic [W-1:0]   aStage;
    logic [W-1:0]   bStage;
    logic [2*W-1:0] product;
    logic [2*W-1:0] mStage;
    logic [2*W-1:0] cStage;
    logic [5:0]     ctlIn;
    logic [5:0]     ctlStage;
    logic [3:0]     modeStage;
    logic           shiftStage;
    logic           validStage;
    logic [P_W-1:0] pReg_q;
    logic [P_W-1:0] pReg_d;
    logic           validReg_q;
    logic [P_W-1:0] prodTerm;
    logic [P_W-1:0] cTerm;
    logic [P_W-1:0] zTerm;

    generate
        if (ABREG == 0) begin : gNoAbReg
            assign aStage = a_i;
            assign bStage = b_i;
        end else begin : gAbReg
            logic [W-1:0] aPipe_q [ABREG];
            logic [W-1:0] bPipe_q [ABREG];

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int i = 0; i < ABREG; i++) begin
                        aPipe_q[i] <= '0;
                        bPipe_q[i] <= '0;
                    end
                end else if (ce_i) begin
                    aPipe_q[0] <= a_i;
                    bPipe_q[0] <= b_i;
                    for (int i = 1; i < ABREG; i++) begin
                        aPipe_q[i] <= aPipe_q[i-1];
                        bPipe_q[i] <= bPipe_q[i-1];
                    end
                end
            end

            assign aStage = aPipe_q[ABREG-1];
            assign bStage = bPipe_q[ABREG-1];
        end
    endgenerate

    assign product = {{W{1'b0}}, aStage} * {{W{1'b0}}, bStage};

    generate
        if (MREG == 0) begin : gNoMReg
            assign mStage = product;
        end else begin : gMReg
            logic [2*W-1:0] mReg_q;

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    mReg_q <= '0;
                end else if (ce_i) begin
                    mReg_q <= product;
                end
            end

            assign mStage = mReg_q;
        end
    endgenerate

    // Control follows the operands stage for stage, so it reaches the P stage with its own data.
    assign ctlIn = {valid_i, shift_i, mode_i};

    generate
        if (CTL_DEPTH == 0) begin : gNoCtlPipe
            assign ctlStage = ctlIn;
        end else begin : gCtlPipe
            logic [5:0] ctlPipe_q [CTL_DEPTH];

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    for (int i = 0; i < CTL_DEPTH; i++) begin
                        ctlPipe_q[i] <= '0;
                    end
                end else if (ce_i) begin
                    ctlPipe_q[0] <= ctlIn;
                    for (int i = 1; i < CTL_DEPTH; i++) begin
                        ctlPipe_q[i] <= ctlPipe_q[i-1];
                    end
                end
            end

            assign ctlStage = ctlPipe_q[CTL_DEPTH-1];
        end
    endgenerate

    assign modeStage  = ctlStage[3:0];
    assign shiftStage = ctlStage[4];
    assign validStage = ctlStage[5];

    // The C register loads regardless of ce_i; a same-edge load is seen by the P stage one cycle later.
    generate
        if (CREG == 0) begin : gNoCReg
            assign cStage = c_i;
        end else begin : gCReg
            logic [2*W-1:0] cReg_q;

            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    cReg_q <= '0;
                end else if (c_en_i) begin
                    cReg_q <= c_i;
                end
            end

            assign cStage = cReg_q;
        end
    endgenerate

    always_comb begin
        prodTerm = '0;
        cTerm    = '0;
        zTerm    = '0;
        if (modeStage[0]) begin
            prodTerm = {{(P_W-2*W){1'b0}}, mStage};
        end
        if (modeStage[1]) begin
            cTerm = {{(P_W-2*W){1'b0}}, cStage};
        end
        case (modeStage[3:2])
            2'b00:   zTerm = '0;
            2'b01:   zTerm = pcin_i;
            2'b10:   zTerm = pcin_i >> W;
            default: zTerm = shiftStage ? (pReg_q >> W) : pReg_q;
        endcase
        pReg_d = prodTerm + cTerm + zTerm;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pReg_q     <= '0;
            validReg_q <= 1'b0;
        end else if (ce_i) begin
            pReg_q     <= pReg_d;
            validReg_q <= validStage;
        end
    end

    assign p_o     = pReg_q[2*W-1:0];
    assign pcout_o = pReg_q;
    assign valid_o = validReg_q;

endmodule

// File: tb/tb_dsp_mac_casc_param.sv
// Directed vector table and corner-case sequences for the MAC slice, plus a latency/parameter
// sweep of six differently pipelined instances against a behavioural reference.
module tb_dsp_mac_casc_param;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        ce = 1'b1;
    logic        valid = 1'b0;
    logic [3:0]  mode = '0;
    logic        shift = 1'b0;
    logic [16:0] a = '0;
    logic [16:0] b = '0;
    logic        cEn = 1'b0;
    logic [33:0] c = '0;
    logic [47:0] pcin = '0;
    logic [33:0] pO;
    logic [47:0] pcout;
    logic        vO;

    logic        s2Valid = 1'b0;
    logic [3:0]  s2Mode = '0;
    logic [16:0] s2A = '0;
    logic [16:0] s2B = '0;
    logic [33:0] s2P;
    logic [47:0] s2Pcout;
    logic        s2V;

    logic        swValid = 1'b0;
    logic [3:0]  swMode = '0;
    logic        swShift = 1'b0;
    logic [16:0] swA = '0;
    logic [16:0] swB = '0;
    logic [33:0] swC = '0;
    logic [47:0] swPcin = '0;
    logic [5:0][33:0] swPo;
    logic [5:0][47:0] swPcout;
    logic [5:0]       swV;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    dsp_mac_casc_param u_dut (
        .clock_i(clk), .reset_n_i(rstN), .ce_i(ce), .valid_i(valid), .mode_i(mode),
        .shift_i(shift), .a_i(a), .b_i(b), .c_en_i(cEn), .c_i(c), .pcin_i(pcin),
        .p_o(pO), .pcout_o(pcout), .valid_o(vO)
    );

    dsp_mac_casc_param u_slice2 (
        .clock_i(clk), .reset_n_i(rstN), .ce_i(ce), .valid_i(s2Valid), .mode_i(s2Mode),
        .shift_i(1'b0), .a_i(s2A), .b_i(s2B), .c_en_i(1'b0), .c_i(34'd0), .pcin_i(pcout),
        .p_o(s2P), .pcout_o(s2Pcout), .valid_o(s2V)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : gSweep
            dsp_mac_casc_param #(
                .ABREG(gi / 2), .MREG(gi % 2), .CREG((gi == 5) ? 0 : 1)
            ) u_sw (
                .clock_i(clk), .reset_n_i(rstN), .ce_i(ce), .valid_i(swValid), .mode_i(swMode),
                .shift_i(swShift), .a_i(swA), .b_i(swB), .c_en_i(1'b1), .c_i(swC),
                .pcin_i(swPcin), .p_o(swPo[gi]), .pcout_o(swPcout[gi]), .valid_o(swV[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [3:0]  mode;
        logic [16:0] a;
        logic [16:0] b;
        logic [33:0] c;
        logic [47:0] pcin;
        logic [47:0] expP;
    } vec_t;

    vec_t vecs[9];

    // Drives the main slice for one clock and returns 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [3:0] m, input logic s,
                                 input logic [16:0] aa, input logic [16:0] bb,
                                 input logic ce_, input logic [33:0] cc);
        valid = v;
        mode  = m;
        shift = s;
        a     = aa;
        b     = bb;
        cEn   = ce_;
        c     = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] refMac(input logic [3:0] m, input logic s,
                                           input logic [16:0] aa, input logic [16:0] bb,
                                           input logic [33:0] cc, input logic [47:0] pc,
                                           input logic [47:0] pPrev);
        logic [47:0] acc;
        acc = '0;
        if (m[0]) acc = acc + 48'(aa) * 48'(bb);
        if (m[1]) acc = acc + 48'(cc);
        case (m[3:2])
            2'b01:   acc = acc + pc;
            2'b10:   acc = acc + (pc >> 17);
            2'b11:   acc = acc + (s ? (pPrev >> 17) : pPrev);
            default: acc = acc;
        endcase
        return acc;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  opM [70];
        logic        opS [70];
        logic        opV [70];
        logic [16:0] opA [70];
        logic [16:0] opB [70];
        logic [47:0] expSw [6];
        logic        expSwV [6];

        vecs[0] = '{4'b0011, 17'h1FFFF, 17'h1FFFF, 34'h1,         48'h0,            48'h3FFFC0002};
        vecs[1] = '{4'b0001, 17'h2,     17'h3,     34'h5,         48'h0,            48'h6};
        vecs[2] = '{4'b0010, 17'h100,   17'h10,    34'h7,         48'h0,            48'h7};
        vecs[3] = '{4'b0101, 17'h3,     17'h5,     34'h0,         48'h123456789ABC, 48'h123456789ACB};
        vecs[4] = '{4'b1001, 17'h1,     17'h1,     34'h0,         48'hFFFFFFFFFFFF, 48'h80000000};
        vecs[5] = '{4'b0111, 17'h1,     17'h1,     34'h1,         48'hFFFFFFFFFFFF, 48'h1};
        vecs[6] = '{4'b0000, 17'h1FFFF, 17'h1FFFF, 34'h3FFFFFFFF, 48'hFF,           48'h0};
        vecs[7] = '{4'b0011, 17'h0,     17'h1FFFF, 34'h3FFFFFFFF, 48'h0,            48'h3FFFFFFFF};
        vecs[8] = '{4'b1011, 17'h1FFFF, 17'h1FFFF, 34'h3FFFFFFFF, 48'hFFFFFFFFFFFF, 48'h87FFBFFFF};

        #3;
        checkOutput("reset_p", 48'(pO), 48'h0);
        checkOutput("reset_pcout", pcout, 48'h0);
        checkOutput("reset_valid", 48'(vO), 48'h0);
        #4 rstN = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        checkOutput("idle_valid", 48'(vO), 48'h0);

        // Isolated ops: issue, two bubbles, result lands on the third edge.
        for (int v = 0; v < 9; v++) begin
            pcin = vecs[v].pcin;
            applyStimulus(1, vecs[v].mode, 0, vecs[v].a, vecs[v].b, 1, vecs[v].c);
            applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("vec%0d_early_valid", v), 48'(vO), 48'h0);
            applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("vec%0d_valid", v), 48'(vO), 48'h1);
            checkOutput($sformatf("vec%0d_pcout", v), pcout, vecs[v].expP);
            checkOutput($sformatf("vec%0d_p", v), 48'(pO), 48'(vecs[v].expP[33:0]));
            applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("vec%0d_flush", v), pcout, 48'h0);
            applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        end
        pcin = '0;
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);

        // C loaded on the same edge the P stage consumes C: the old value must be used.
        applyStimulus(1, 4'b0010, 0, 0, 0, 1, 34'h10);
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0, 0, 0, 0, 1, 34'h99);
        checkOutput("c_old_value", pcout, 48'h10);
        applyStimulus(1, 4'b0010, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        checkOutput("c_new_value", pcout, 48'h99);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);

        // Back-to-back accumulate with Z=P.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) applyStimulus(1, 4'b1101, 0, 17'd2, 17'd3, 0, 0);
            else       applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            if (i >= 2 && i <= 5) checkOutput($sformatf("acc_step%0d", i - 2), pcout, 48'(6 * (i - 1)));
        end
        checkOutput("acc_p_final", pcout, 48'h0);

        // Load P, then shift it down by W twice.
        for (int i = 0; i < 8; i++) begin
            if (i == 0)      applyStimulus(1, 4'b0010, 0, 0, 0, 1, 34'h300000005);
            else if (i < 3)  applyStimulus(1, 4'b1100, 1, 0, 0, 0, 0);
            else             applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            if (i == 2) checkOutput("shift_load", pcout, 48'h300000005);
            if (i == 3) checkOutput("shift_once", pcout, 48'h18000);
            if (i == 4) begin
                checkOutput("shift_twice", pcout, 48'h0);
                checkOutput("shift_twice_valid", 48'(vO), 48'h1);
            end
        end

        // Cascade: slice 2 adds slice 1's P >> W.
        pcin = 48'h500000000;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                s2Valid = 1'b1; s2Mode = 4'b1001; s2A = 17'd1; s2B = 17'd1;
            end else begin
                s2Valid = 1'b0; s2Mode = 4'b0; s2A = '0; s2B = '0;
            end
            if (i == 0) applyStimulus(1, 4'b0100, 0, 0, 0, 0, 0);
            else        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            if (i == 2) checkOutput("casc_slice1", pcout, 48'h500000000);
            if (i == 3) begin
                checkOutput("casc_slice2", s2Pcout, 48'h28001);
                checkOutput("casc_slice2_p", 48'(s2P), 48'h28001);
                checkOutput("casc_slice2_valid", 48'(s2V), 48'h1);
            end
        end
        pcin = '0;

        // Stall: four ce_i=0 edges freeze the stream and delay later results by four cycles.
        for (int i = 0; i < 12; i++) begin
            ce = !(i >= 4 && i <= 7);
            case (i)
                0:       applyStimulus(1, 4'b0001, 0, 17'd3, 17'd4, 0, 0);
                1:       applyStimulus(1, 4'b0001, 0, 17'd5, 17'd6, 0, 0);
                2:       applyStimulus(1, 4'b0001, 0, 17'd7, 17'd8, 0, 0);
                3:       applyStimulus(1, 4'b0001, 0, 17'd9, 17'd10, 0, 0);
                default: applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            endcase
            if (i == 2) checkOutput("stall_r0", pcout, 48'd12);
            if (i >= 3 && i <= 7) begin
                checkOutput($sformatf("stall_hold%0d", i), pcout, 48'd30);
                checkOutput($sformatf("stall_hold%0d_valid", i), 48'(vO), 48'h1);
            end
            if (i == 8) checkOutput("stall_r2", pcout, 48'd56);
            if (i == 9) checkOutput("stall_r3", pcout, 48'd90);
            if (i == 10) checkOutput("stall_drain_valid", 48'(vO), 48'h0);
        end
        ce = 1'b1;

        // Reset pulse mid-stream discards in-flight ops.
        for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, 0, 17'd4, 17'd4, 0, 0);
        checkOutput("prereset_p", pcout, 48'd16);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midreset_pcout", pcout, 48'h0);
        checkOutput("midreset_p", 48'(pO), 48'h0);
        checkOutput("midreset_valid", 48'(vO), 48'h0);
        #3 rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("postreset_valid%0d", i), 48'(vO), 48'h0);
        end
        applyStimulus(1, 4'b0001, 0, 17'd5, 17'd5, 0, 0);
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        checkOutput("postreset_early", 48'(vO), 48'h0);
        applyStimulus(0, 4'b0, 0, 0, 0, 0, 0);
        checkOutput("postreset_result", pcout, 48'd25);
        checkOutput("postreset_result_valid", 48'(vO), 48'h1);

        // Parameter sweep against the reference model.
        swC    = 34'({$urandom(), $urandom()});
        swPcin = 48'({$urandom(), $urandom()});
        rstN = 1'b0;
        #2 rstN = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < 6; g++) begin
            expSw[g]  = '0;
            expSwV[g] = 1'b0;
        end
        for (int n = 0; n < 64; n++) begin
            if (n < 60) begin
                opM[n] = 4'($urandom());
                opS[n] = 1'($urandom());
                opV[n] = 1'($urandom());
                opA[n] = 17'($urandom());
                opB[n] = 17'($urandom());
            end else begin
                opM[n] = '0; opS[n] = 1'b0; opV[n] = 1'b0; opA[n] = '0; opB[n] = '0;
            end
            swMode = opM[n]; swShift = opS[n]; swValid = opV[n]; swA = opA[n]; swB = opB[n];
            @(posedge clk);
            for (int g = 0; g < 6; g++) begin
                int lat;
                int idx;
                lat = g / 2 + g % 2 + 1;
                idx = n - lat + 1;
                if (idx >= 0) begin
                    expSw[g]  = refMac(opM[idx], opS[idx], opA[idx], opB[idx], swC, swPcin, expSw[g]);
                    expSwV[g] = opV[idx];
                end else begin
                    expSw[g]  = '0;
                    expSwV[g] = 1'b0;
                end
            end
            #1;
            for (int g = 0; g < 6; g++) begin
                checkOutput($sformatf("sweep%0d_n%0d_pcout", g, n), swPcout[g], expSw[g]);
                checkOutput($sformatf("sweep%0d_n%0d_p", g, n), 48'(swPo[g]), 48'(expSw[g][33:0]));
                checkOutput($sformatf("sweep%0d_n%0d_valid", g, n), 48'(swV[g]), 48'(expSwV[g]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
